// File: rtl/seq_div_step.sv
// div_step: one restoring shift-subtract step for seq_div.
// in: acc, q_msb, d | out: acc_nxt, q_bit
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] acc,
  input  logic         q_msb,
  input  logic [N-1:0] d,
  output logic [N-1:0] acc_nxt,
  output logic         q_bit
);

  logic [N:0] s;
  logic [N:0] t;

  always_comb begin
    s = {acc, q_msb};
    t = s - {1'b0, d};
    q_bit = ~t[N];
    // Result is below d either way, so it fits in N bits.
    acc_nxt = t[N] ? s[N-1:0] : t[N-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider, one quotient bit per clock.
// in: clk, rst_n, load, a, b | out: valid, q, r, dbz
module seq_div #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         valid,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dbz
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic          running, running_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  d, d_nxt;
  logic [N-1:0]  qr, qr_nxt;
  // Partial remainder: its top bit is always zero between steps,
  // so only the low N bits are kept.
  logic [N-1:0]  acc, acc_nxt;
  logic          dbz_q, dbz_nxt;
  logic [N-1:0]  step_acc;
  logic          step_bit;

  div_step #(.N(N)) u_step (
    .acc    (acc),
    .q_msb  (qr[N-1]),
    .d      (d),
    .acc_nxt(step_acc),
    .q_bit  (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      d       <= '0;
      qr      <= '0;
      acc     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      running <= running_nxt;
      cnt     <= cnt_nxt;
      d       <= d_nxt;
      qr      <= qr_nxt;
      acc     <= acc_nxt;
      dbz_q   <= dbz_nxt;
    end
  end

  always_comb begin
    running_nxt = running;
    cnt_nxt     = cnt;
    d_nxt       = d;
    qr_nxt      = qr;
    acc_nxt     = acc;
    dbz_nxt     = dbz_q;
    unique case (1'b1)
      load: begin
        d_nxt       = b;
        qr_nxt      = a;
        acc_nxt     = '0;
        cnt_nxt     = CNT_LAST;
        running_nxt = 1'b1;
        dbz_nxt     = (b == '0);
      end
      (running && !load): begin
        acc_nxt     = step_acc;
        qr_nxt      = {qr[N-2:0], step_bit};
        cnt_nxt     = cnt - 1'b1;
        running_nxt = (cnt != '0);
      end
      default: ;
    endcase
  end

  assign valid = ~running;
  assign q     = qr;
  assign r     = acc;
  assign dbz   = dbz_q;

endmodule
